alu_serial_seq: RTL

ALU_SERIAL_SEQ -- requirements
Module: alu_serial_seq

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_bit_slice.sv | 47 ++++
 rtl/alu_serial_seq.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the bit-serial ALU:
//   - 4-bit opcode constants, laid out as {ainv, binv, opA, opB}
//   - FSM state enum used by alu_serial_seq
//   - is_less(): true when an opcode selects the set-less-than path
// No ports; imported with "import alu_pkg::*;".
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Selector 10 doubles as XOR (binv=0) and LESS (binv=1).
    function automatic logic is_less(input logic [3:0] op);
        return (op[1:0] == 2'b10) && op[2];
    endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// -----------------------------------------------------------------------------
// alu_bit_slice
// Combinational 1-bit ALU cell. Operand inversion happens before the
// function select, so the same cell covers AND/OR/XOR/ADD/SUB/NOR/SLT.
// Ports:
//   a, b        operand bits
//   less        value to emit on the LESS selection
//   cin         carry in
//   ainv, binv  invert a / b before selection
//   opA, opB    function select: 00 AND, 01 OR, 10 XOR/LESS, 11 SUM
//   result      selected output bit
//   cout        carry out of the full adder
//   sum         raw full-adder sum (needed at the MSB for SLT)
// -----------------------------------------------------------------------------
module alu_bit_slice (
    input  logic a,
    input  logic b,
    input  logic less,
    input  logic cin,
    input  logic ainv,
    input  logic binv,
    input  logic opA,
    input  logic opB,
    output logic result,
    output logic cout,
    output logic sum
);

    logic w_a;
    logic w_b;

    assign w_a  = a ^ ainv;
    assign w_b  = b ^ binv;
    assign sum  = w_a ^ w_b ^ cin;
    assign cout = (w_a & w_b) | (cin & (w_a ^ w_b));

    always_comb begin
        result = 1'b0;
        case ({opA, opB})
            2'b00:   result = w_a & w_b;
            2'b01:   result = w_a | w_b;
            2'b10:   result = binv ? less : (w_a ^ w_b);
            default: result = sum;
        endcase
    end

endmodule

// File: rtl/alu_serial_seq.sv
// -----------------------------------------------------------------------------
// alu_serial_seq
// Bit-serial ALU: accepts operands with a valid/ready handshake, processes
// one bit per cycle LSB first through a single alu_bit_slice, applies the
// SLT fix-up in a one-cycle FIX state, then presents the result until the
// consumer takes it. Latency from accept to out_valid is WIDTH+2 cycles
// for every opcode.
//
// Parameters:
//   WIDTH      operand/result width, 4..64
// Ports:
//   clk        clock, rising edge
//   reset      synchronous, active-high
//   in_valid   operand/opcode offer
//   in_ready   high only while idle
//   a, b       operands
//   opcode     {ainv, binv, opA, opB}
//   out_valid  result available (held until out_ready)
//   out_ready  consumer accepts result
//   result     operation result
//   cout       carry out of the MSB
//   overflow   signed overflow (carry into MSB XOR carry out of MSB)
//   zero       only with ALU_SERIAL_ZERO_EN: high when result == 0
//
// Build option: define ALU_SERIAL_ZERO_EN to add the zero output.
// -----------------------------------------------------------------------------
module alu_serial_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
`ifdef ALU_SERIAL_ZERO_EN
    ,
    output logic             zero
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_res;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic               r_cout;
    logic               r_ovf;
    logic               r_msb_sum;

    logic               w_accept;
    logic               w_last_bit;
    logic               w_res_bit;
    logic               w_cout;
    logic               w_sum;
    logic               w_less_bit;

    assign w_accept   = in_valid && (r_state == ST_IDLE);
    assign w_last_bit = (r_cnt == CNT_W'(WIDTH - 1));
    // Set-less-than outcome: sign of a-b corrected for overflow.
    assign w_less_bit = r_msb_sum ^ r_ovf;

    // Operands are shifted right so the slice always sees bit 0.
    alu_bit_slice u_slice (
        .a      (r_a[0]),
        .b      (r_b[0]),
        .less   (1'b0),
        .cin    (r_carry),
        .ainv   (r_op[3]),
        .binv   (r_op[2]),
        .opA    (r_op[1]),
        .opB    (r_op[0]),
        .result (w_res_bit),
        .cout   (w_cout),
        .sum    (w_sum)
    );

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last_bit) begin
                    w_state_nxt = ST_FIX;
                end
            end
            ST_FIX: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand capture and shifting; no reset needed since every operation
    // reloads these on accept before they are consumed.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a  <= a;
            r_b  <= b;
            r_op <= opcode;
        end else if (r_state == ST_RUN) begin
            r_a  <= r_a >> 1;
            r_b  <= r_b >> 1;
        end
    end

    // Control, carry chain and result accumulation
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_res     <= '0;
            r_carry   <= 1'b0;
            r_cout    <= 1'b0;
            r_ovf     <= 1'b0;
            r_msb_sum <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_cnt   <= '0;
                        // binv doubles as the +1 of two's-complement subtract.
                        r_carry <= opcode[2];
                    end
                end
                ST_RUN: begin
                    // New bits enter at the top; after WIDTH shifts the
                    // first (LSB) bit has reached position 0.
                    r_res   <= {w_res_bit, r_res[WIDTH-1:1]};
                    r_carry <= w_cout;
                    if (w_last_bit) begin
                        r_cnt     <= '0;
                        r_cout    <= w_cout;
                        r_ovf     <= r_carry ^ w_cout;
                        r_msb_sum <= w_sum;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_FIX: begin
                    if (is_less(r_op)) begin
                        r_res[0] <= w_less_bit;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ALU_SERIAL_ZERO_EN
    logic r_zero;

    // Running AND of inverted result bits; FIX folds in the SLT bit 0,
    // whose RUN value was always 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_zero <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_zero <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_zero <= r_zero & ~w_res_bit;
                end
                ST_FIX: begin
                    if (is_less(r_op)) begin
                        r_zero <= r_zero & ~w_less_bit;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign zero = r_zero;
`endif

    assign result   = r_res;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule
